vec_exec_seq: RTL and testbench

- Parametrised, multi-cycle vector execution unit and successor to the single-beat combinational datapath.
- Accepts one vector instruction per request handshake and walks the register group (LMUL = 1/2/4/8) one register per beat through a synchronous register file.
- Supports SEW 8/16/32 for vxor, vmacc and vredsum.
- Writes results back and signals completion; sits between the control unit and the vector register file.

---
 rtl/vec_exec_pkg.sv | 46 ++++
 rtl/vec_lane_alu.sv | 53 +++++
 rtl/vec_exec_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_vec_exec_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_exec_pkg.sv
// Shared types and helpers for the multi-cycle vector execution unit.
package vec_exec_pkg;

  localparam int MAX_LMUL_LOG2_DEF = 3;
  localparam int LMUL_MAX          = 1 << MAX_LMUL_LOG2_DEF;

  typedef enum logic [1:0] {
    OP_VXOR    = 2'd0,
    OP_VMACC   = 2'd1,
    OP_VREDSUM = 2'd2,
    OP_RSVD    = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_ILL = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_EX   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int elems_per_reg(input sew_e sew, input int vlen);
    case (sew)
      SEW_8:   return vlen / 8;
      SEW_16:  return vlen / 16;
      SEW_32:  return vlen / 32;
      default: return 0;
    endcase
  endfunction

  // Keeps the low SEW bits of a 32-bit scalar.
  function automatic logic [31:0] sew_mask(input sew_e sew);
    case (sew)
      SEW_8:   return 32'h0000_00FF;
      SEW_16:  return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Combinational SEW-aware arithmetic on one vector register: xor, multiply-accumulate
// and the sum of all elements of the second source.
module vec_lane_alu
  import vec_exec_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  sew_e             sew,
  input  logic [VLEN-1:0]  a,
  input  logic [VLEN-1:0]  b,
  input  logic [VLEN-1:0]  c,
  output logic [VLEN-1:0]  xor_res,
  output logic [VLEN-1:0]  macc_res,
  output logic [31:0]      sum_res
);

  localparam int E8  = elems_per_reg(SEW_8, VLEN);
  localparam int E16 = elems_per_reg(SEW_16, VLEN);
  localparam int E32 = elems_per_reg(SEW_32, VLEN);

  assign xor_res = a ^ b;

  // Element loop per SEW; products and sums wrap at the element width.
  always_comb begin
    macc_res = '0;
    sum_res  = 32'd0;
    case (sew)
      SEW_8: begin
        for (int i = 0; i < E8; i++) begin
          macc_res[i*8 +: 8] = a[i*8 +: 8] * b[i*8 +: 8] + c[i*8 +: 8];
          sum_res = sum_res + {24'd0, b[i*8 +: 8]};
        end
      end
      SEW_16: begin
        for (int i = 0; i < E16; i++) begin
          macc_res[i*16 +: 16] = a[i*16 +: 16] * b[i*16 +: 16] + c[i*16 +: 16];
          sum_res = sum_res + {16'd0, b[i*16 +: 16]};
        end
      end
      SEW_32: begin
        for (int i = 0; i < E32; i++) begin
          macc_res[i*32 +: 32] = a[i*32 +: 32] * b[i*32 +: 32] + c[i*32 +: 32];
          sum_res = sum_res + b[i*32 +: 32];
        end
      end
      default: begin
        macc_res = '0;
        sum_res  = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/vec_exec_seq.sv
// Multi-cycle vector execution unit: walks an LMUL register group one register per
// read/execute beat pair and writes results back to the vector register file.
module vec_exec_seq
  import vec_exec_pkg::*;
#(
  parameter int VLEN          = 128,
  parameter int NREG          = 32,
  parameter int MAX_LMUL_LOG2 = MAX_LMUL_LOG2_DEF
) (
  input  logic                  vsi_clk,
  input  logic                  vsi_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [1:0]            req_sew,
  input  logic [1:0]            req_lmul,
  input  logic [4:0]            req_vd,
  input  logic [4:0]            req_vs1,
  input  logic [4:0]            req_vs2,
  output logic [2:0][4:0]       rf_raddr,
  input  logic [2:0][VLEN-1:0]  rf_rdata,
  output logic                  rf_we,
  output logic [4:0]            rf_waddr,
  output logic [VLEN/8-1:0]     rf_wstrb,
  output logic [VLEN-1:0]       rf_wdata,
  output logic                  done_valid,
  output logic                  done_err
);

  localparam int BW = MAX_LMUL_LOG2 + 1;
  localparam int SW = VLEN / 8;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  sew_e              sew_q, sew_d;
  logic [1:0]        lmul_q, lmul_d;
  logic [4:0]        vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              err_q, err_d;
  logic [31:0]       acc_q, acc_d;
  logic              req_ready_q, req_ready_d;
  logic [2:0][4:0]   rf_raddr_q, rf_raddr_d;
  logic              rf_we_q, rf_we_d;
  logic [4:0]        rf_waddr_q, rf_waddr_d;
  logic [SW-1:0]     rf_wstrb_q, rf_wstrb_d;
  logic [VLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic              done_valid_q, done_valid_d;
  logic              done_err_q, done_err_d;

  logic              req_bad_s;
  logic [BW-1:0]     n_last_s, beat_nxt_s;
  logic              last_s;
  logic [31:0]       acc_base_s, acc_new_s;
  logic [VLEN-1:0]   alu_xor_s, alu_macc_s;
  logic [31:0]       alu_sum_s;

  // A group base must be aligned to the group size and the group must fit the file.
  function automatic logic base_bad(input logic [4:0] base, input logic [1:0] lmul);
    logic [6:0] n;
    n = 7'd1 << lmul;
    return ((base & 5'(n - 7'd1)) != 5'd0) || (({2'b00, base} + n) > 7'(NREG));
  endfunction

  function automatic logic [SW-1:0] red_strb(input sew_e s);
    case (s)
      SEW_8:   return SW'(4'b0001);
      SEW_16:  return SW'(4'b0011);
      default: return SW'(4'b1111);
    endcase
  endfunction

  vec_lane_alu #(.VLEN(VLEN)) u_alu (
    .sew      (sew_q),
    .a        (rf_rdata[0]),
    .b        (rf_rdata[1]),
    .c        (rf_rdata[2]),
    .xor_res  (alu_xor_s),
    .macc_res (alu_macc_s),
    .sum_res  (alu_sum_s)
  );

  // vredsum only reads one vs1 register and writes one vd register, so only vs2 is a group.
  assign req_bad_s = (op_e'(req_op) == OP_RSVD) || (sew_e'(req_sew) == SEW_ILL) ||
                     ({30'd0, req_lmul} > 32'(MAX_LMUL_LOG2)) ||
                     base_bad(req_vs2, req_lmul) ||
                     ((op_e'(req_op) != OP_VREDSUM) &&
                      (base_bad(req_vd, req_lmul) || base_bad(req_vs1, req_lmul)));

  assign n_last_s   = (BW'(1) << lmul_q) - BW'(1);
  assign last_s     = (beat_q == n_last_s);
  assign beat_nxt_s = beat_q + BW'(1);
  assign acc_base_s = (beat_q == '0) ? (rf_rdata[0][31:0] & sew_mask(sew_q)) : acc_q;
  assign acc_new_s  = (acc_base_s + alu_sum_s) & sew_mask(sew_q);

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sew_d        = sew_q;
    lmul_d       = lmul_q;
    vd_d         = vd_q;
    vs1_d        = vs1_q;
    vs2_d        = vs2_q;
    beat_d       = beat_q;
    err_d        = err_q;
    acc_d        = acc_q;
    req_ready_d  = 1'b0;
    rf_raddr_d   = '0;
    rf_we_d      = 1'b0;
    rf_waddr_d   = 5'd0;
    rf_wstrb_d   = '0;
    rf_wdata_d   = '0;
    done_valid_d = 1'b0;
    done_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d   = op_e'(req_op);
          sew_d  = sew_e'(req_sew);
          lmul_d = req_lmul;
          vd_d   = req_vd;
          vs1_d  = req_vs1;
          vs2_d  = req_vs2;
          beat_d = '0;
          acc_d  = 32'd0;
          if (req_bad_s) begin
            state_d      = S_DONE;
            err_d        = 1'b1;
            done_valid_d = 1'b1;
            done_err_d   = 1'b1;
          end else begin
            state_d    = S_RD;
            err_d      = 1'b0;
            rf_raddr_d = {req_vd, req_vs2, req_vs1};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_RD: begin
        state_d = S_EX;
      end
      S_EX: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = vd_q + 5'(beat_q);
        rf_wstrb_d = '1;
        case (op_q)
          OP_VXOR:  rf_wdata_d = alu_xor_s;
          OP_VMACC: rf_wdata_d = alu_macc_s;
          OP_VREDSUM: begin
            acc_d      = acc_new_s;
            rf_we_d    = last_s;
            rf_waddr_d = last_s ? vd_q : 5'd0;
            rf_wstrb_d = last_s ? red_strb(sew_q) : '0;
            rf_wdata_d = last_s ? VLEN'(acc_new_s) : '0;
          end
          default: begin
            rf_we_d    = 1'b0;
            rf_waddr_d = 5'd0;
            rf_wstrb_d = '0;
          end
        endcase
        if (last_s) begin
          state_d      = S_DONE;
          done_valid_d = 1'b1;
          done_err_d   = err_q;
        end else begin
          state_d       = S_RD;
          beat_d        = beat_nxt_s;
          rf_raddr_d[0] = (op_q == OP_VREDSUM) ? vs1_q : vs1_q + 5'(beat_nxt_s);
          rf_raddr_d[1] = vs2_q + 5'(beat_nxt_s);
          rf_raddr_d[2] = vd_q + 5'(beat_nxt_s);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge vsi_clk) begin
    if (vsi_rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_VXOR;
      sew_q        <= SEW_8;
      lmul_q       <= 2'd0;
      vd_q         <= 5'd0;
      vs1_q        <= 5'd0;
      vs2_q        <= 5'd0;
      beat_q       <= '0;
      err_q        <= 1'b0;
      acc_q        <= 32'd0;
      req_ready_q  <= 1'b0;
      rf_raddr_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wstrb_q   <= '0;
      rf_wdata_q   <= '0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sew_q        <= sew_d;
      lmul_q       <= lmul_d;
      vd_q         <= vd_d;
      vs1_q        <= vs1_d;
      vs2_q        <= vs2_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      acc_q        <= acc_d;
      req_ready_q  <= req_ready_d;
      rf_raddr_q   <= rf_raddr_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wstrb_q   <= rf_wstrb_d;
      rf_wdata_q   <= rf_wdata_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign rf_raddr   = rf_raddr_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wstrb   = rf_wstrb_q;
  assign rf_wdata   = rf_wdata_q;
  assign done_valid = done_valid_q;
  assign done_err   = done_err_q;

endmodule

// File: tb/tb_vec_exec_seq.sv
// Directed self-checking bench for vec_exec_seq with a behavioural register file.
module tb_vec_exec_seq;

  localparam int VLEN = 128;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_valid, req_ready;
  logic [1:0]           req_op, req_sew, req_lmul;
  logic [4:0]           req_vd, req_vs1, req_vs2;
  logic [2:0][4:0]      rf_raddr;
  logic [2:0][VLEN-1:0] rf_rdata;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [VLEN/8-1:0]    rf_wstrb;
  logic [VLEN-1:0]      rf_wdata;
  logic                 done_valid, done_err;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [VLEN-1:0] mem [32];
  int              wr_cyc[$];
  logic [4:0]      wr_addr[$];
  logic [15:0]     wr_strb[$];
  logic [VLEN-1:0] wr_data[$];
  int              dn_cyc[$];
  logic            dn_err[$];

  vec_exec_seq #(.VLEN(VLEN), .NREG(32), .MAX_LMUL_LOG2(3)) dut (
    .vsi_clk(clk), .vsi_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sew(req_sew), .req_lmul(req_lmul),
    .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wstrb(rf_wstrb), .rf_wdata(rf_wdata),
    .done_valid(done_valid), .done_err(done_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency, byte-strobed writes.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rf_rdata[k] <= mem[rf_raddr[k]];
    if (rf_we)
      for (int b = 0; b < VLEN/8; b++)
        if (rf_wstrb[b]) mem[rf_waddr][b*8 +: 8] <= rf_wdata[b*8 +: 8];
  end

  always @(negedge clk) begin
    if (rf_we) begin
      wr_cyc.push_back(cyc); wr_addr.push_back(rf_waddr);
      wr_strb.push_back(rf_wstrb); wr_data.push_back(rf_wdata);
    end
    if (done_valid) begin
      dn_cyc.push_back(cyc); dn_err.push_back(done_err);
    end
  end

  task automatic fill(input int r, input logic [31:0] w);
    mem[r] = {4{w}};
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_strb.delete(); wr_data.delete();
    dn_cyc.delete(); dn_err.delete();
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sew, input logic [1:0] lmul,
                       input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                       output int t);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL issue_ready_timeout: req_ready=%b required 1", req_ready); n_bad++;
    end
    req_op = op; req_sew = sew; req_lmul = lmul;
    req_vd = vd; req_vs1 = vs1; req_vs2 = vs2;
    req_valid = 1'b1;
    t = cyc;
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0;
    req_op = 2'd0; req_sew = 2'd0; req_lmul = 2'd0;
    req_vd = 5'd0; req_vs1 = 5'd0; req_vs2 = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({req_ready, rf_we, done_valid, done_err} !== 4'b0000) begin
      $display("FAIL reset_ctrl: ready/we/done/err=%b required 0000",
               {req_ready, rf_we, done_valid, done_err}); n_bad++;
    end
    n_vec++;
    if (rf_raddr !== 15'd0 || rf_wdata !== '0 || rf_wstrb !== 16'd0 || rf_waddr !== 5'd0) begin
      $display("FAIL reset_data: raddr=%h waddr=%h strb=%h required all 0", rf_raddr, rf_waddr, rf_wstrb);
      n_bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL reset_ready_after: got %b required 1", req_ready); n_bad++;
    end
  endtask

  task automatic test_vxor();
    int t;
    logic [VLEN-1:0] exp_d;
    exp_d = {4{32'hF0F0_0F0F}};
    fill(1, 32'h0); fill(2, 32'hFFFF_0000); fill(3, 32'h0F0F_0F0F);
    clear_logs();
    issue(2'd0, 2'd2, 2'd0, 5'd1, 5'd2, 5'd3, t);
    repeat (8) @(negedge clk);
    n_vec++;
    if (wr_cyc.size() != 1) begin
      $display("FAIL vxor_nwrites: got %0d required 1", wr_cyc.size()); n_bad++;
    end else begin
      n_vec++;
      if (wr_cyc[0] != t + 3 || wr_addr[0] !== 5'd1 || wr_strb[0] !== 16'hFFFF) begin
        $display("FAIL vxor_write: cyc=T+%0d addr=%0d strb=%h required T+3 1 ffff",
                 wr_cyc[0] - t, wr_addr[0], wr_strb[0]); n_bad++;
      end
      n_vec++;
      if (wr_data[0] !== exp_d) begin
        $display("FAIL vxor_data: got %h required %h", wr_data[0], exp_d); n_bad++;
      end
    end
    n_vec++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != t + 3 || dn_err[0] !== 1'b0) begin
      $display("FAIL vxor_done: count=%0d required 1 at T+3 err 0", dn_cyc.size()); n_bad++;
    end
  endtask

  task automatic test_vmacc();
    int t;
    logic [VLEN-1:0] exp_d;
    // 3*0x60 = 0x120 -> 0x20 mod 256, plus 0x40 gives 0x60 per byte.
    exp_d = {16{8'h60}};
    for (int i = 0; i < 4; i++) begin
      fill(16 + i, 32'h0303_0303); fill(20 + i, 32'h6060_6060); fill(8 + i, 32'h4040_4040);
    end
    clear_logs();
    issue(2'd1, 2'd0, 2'd2, 5'd8, 5'd16, 5'd20, t);
    repeat (14) @(negedge clk);
    n_vec++;
    if (wr_cyc.size() != 4) begin
      $display("FAIL vmacc_nwrites: got %0d required 4", wr_cyc.size()); n_bad++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (wr_cyc[i] != t + 3 + 2*i || wr_addr[i] !== 5'(8 + i) ||
            wr_strb[i] !== 16'hFFFF || wr_data[i] !== exp_d) begin
          $display("FAIL vmacc_beat%0d: cyc=T+%0d addr=%0d strb=%h data=%h required T+%0d %0d ffff %h",
                   i, wr_cyc[i] - t, wr_addr[i], wr_strb[i], wr_data[i], 3 + 2*i, 8 + i, exp_d);
          n_bad++;
        end
      end
    end
    n_vec++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != t + 9 || dn_err[0] !== 1'b0) begin
      $display("FAIL vmacc_done: count=%0d required 1 at T+9 err 0", dn_cyc.size()); n_bad++;
    end
  endtask

  task automatic test_vredsum();
    int t;
    fill(4, 32'h7777_0005); fill(6, 32'h0001_0001); fill(7, 32'h0001_0001);
    fill(2, 32'hDEAD_BEEF);
    clear_logs();
    issue(2'd2, 2'd1, 2'd1, 5'd2, 5'd4, 5'd6, t);
    repeat (10) @(negedge clk);
    n_vec++;
    if (wr_cyc.size() != 1) begin
      $display("FAIL vredsum_nwrites: got %0d required 1", wr_cyc.size()); n_bad++;
    end else begin
      n_vec++;
      if (wr_cyc[0] != t + 5 || wr_addr[0] !== 5'd2 || wr_strb[0] !== 16'h0003) begin
        $display("FAIL vredsum_write: cyc=T+%0d addr=%0d strb=%h required T+5 2 0003",
                 wr_cyc[0] - t, wr_addr[0], wr_strb[0]); n_bad++;
      end
      n_vec++;
      if (wr_data[0] !== 128'h15) begin
        $display("FAIL vredsum_data: got %h required 15", wr_data[0]); n_bad++;
      end
    end
    n_vec++;
    if (dn_cyc.size() != 1 || dn_cyc[0] != t + 5) begin
      $display("FAIL vredsum_done: count=%0d required 1 at T+5", dn_cyc.size()); n_bad++;
    end
  endtask

  task automatic test_illegal();
    int t;
    logic [1:0] ops [3];
    logic [1:0] sews [3];
    logic [1:0] lmuls [3];
    logic [4:0] vds [3];
    ops   = '{2'd0, 2'd0, 2'd3};
    sews  = '{2'd3, 2'd2, 2'd2};
    lmuls = '{2'd0, 2'd2, 2'd0};
    vds   = '{5'd1, 5'd5, 5'd1};
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      issue(ops[i], sews[i], lmuls[i], vds[i], 5'd8, 5'd12, t);
      repeat (5) @(negedge clk);
      n_vec++;
      if (wr_cyc.size() != 0) begin
        $display("FAIL illegal%0d_writes: got %0d required 0", i, wr_cyc.size()); n_bad++;
      end
      n_vec++;
      if (dn_cyc.size() != 1 || dn_cyc[0] != t + 1 || dn_err[0] !== 1'b1) begin
        $display("FAIL illegal%0d_done: count=%0d required 1 at T+1 with err", i, dn_cyc.size());
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_midop();
    int t;
    for (int i = 0; i < 8; i++) begin fill(8 + i, 32'h1234_5678); fill(16 + i, 32'h0F0F_0F0F); end
    clear_logs();
    issue(2'd0, 2'd2, 2'd3, 5'd0, 5'd8, 5'd16, t);
    while (cyc < t + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({req_ready, rf_we, done_valid} !== 3'b000) begin
      $display("FAIL midrst_state: ready/we/done=%b required 000", {req_ready, rf_we, done_valid});
      n_bad++;
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req_ready !== 1'b1) begin
      $display("FAIL midrst_ready: got %b required 1", req_ready); n_bad++;
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (wr_cyc.size() != 2 || dn_cyc.size() != 0) begin
      $display("FAIL midrst_writes: writes=%0d dones=%0d required 2 0", wr_cyc.size(), dn_cyc.size());
      n_bad++;
    end
    fill(2, 32'hFFFF_0000); fill(3, 32'h0F0F_0F0F);
    clear_logs();
    issue(2'd0, 2'd2, 2'd0, 5'd1, 5'd2, 5'd3, t);
    repeat (8) @(negedge clk);
    n_vec++;
    if (wr_cyc.size() != 1 || dn_cyc.size() != 1 || dn_cyc[0] != t + 3 ||
        wr_data[0] !== {4{32'hF0F0_0F0F}}) begin
      $display("FAIL midrst_resume: writes=%0d dones=%0d required 1 1 at T+3", wr_cyc.size(), dn_cyc.size());
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int t, t2;
    fill(4, 32'hAAAA_5555); fill(5, 32'hAAAA_5555); fill(6, 32'hFFFF_FFFF); fill(7, 32'hFFFF_FFFF);
    clear_logs();
    req_op = 2'd0; req_sew = 2'd2; req_lmul = 2'd1;
    req_vd = 5'd2; req_vs1 = 5'd4; req_vs2 = 5'd6;
    @(negedge clk);
    for (int g = 0; g < 50 && !req_ready; g++) @(negedge clk);
    req_valid = 1'b1;
    t = cyc;
    t2 = -1;
    for (int g = 0; g < 20 && t2 < 0; g++) begin
      @(negedge clk);
      if (req_ready) t2 = cyc;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (10) @(negedge clk);
    n_vec++;
    if (t2 != t + 6) begin
      $display("FAIL b2b_accept: second accept at T+%0d required T+6", t2 - t); n_bad++;
    end
    n_vec++;
    if (dn_cyc.size() != 2 || wr_cyc.size() != 4) begin
      $display("FAIL b2b_count: dones=%0d writes=%0d required 2 4", dn_cyc.size(), wr_cyc.size());
      n_bad++;
    end else begin
      n_vec++;
      if (dn_cyc[0] != t + 5 || dn_cyc[1] != t + 11 || wr_data[0] !== {4{32'h5555_AAAA}}) begin
        $display("FAIL b2b_timing: dones at T+%0d T+%0d data=%h required T+5 T+11 5555aaaa..",
                 dn_cyc[0] - t, dn_cyc[1] - t, wr_data[0]); n_bad++;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    test_reset();
    test_vxor();
    test_vmacc();
    test_vredsum();
    test_illegal();
    test_reset_midop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
